// File: rtl/hm_pkg.sv
// Shared definitions for the microcoded machine: control-word bit map,
// opcode encoding and default datapath widths.
package hm_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   localparam int HLT_B  = 15;
   localparam int AI_B   = 14;
   localparam int AO_B   = 13;
   localparam int BI_B   = 12;
   localparam int MI_B   = 11;
   localparam int RR_B   = 10;
   localparam int RW_B   = 9;
   localparam int II_B   = 8;
   localparam int IO_B   = 7;
   localparam int CI_B   = 6;
   localparam int CO_B   = 5;
   localparam int CE_B   = 4;
   localparam int SUB_B  = 3;
   localparam int ALUO_B = 2;
   localparam int DI_B   = 1;
   localparam int FL_B   = 0;

   localparam logic [15:0] HLT_M  = 16'h8000;
   localparam logic [15:0] AI_M   = 16'h4000;
   localparam logic [15:0] AO_M   = 16'h2000;
   localparam logic [15:0] BI_M   = 16'h1000;
   localparam logic [15:0] MI_M   = 16'h0800;
   localparam logic [15:0] RR_M   = 16'h0400;
   localparam logic [15:0] RW_M   = 16'h0200;
   localparam logic [15:0] II_M   = 16'h0100;
   localparam logic [15:0] IO_M   = 16'h0080;
   localparam logic [15:0] CI_M   = 16'h0040;
   localparam logic [15:0] CO_M   = 16'h0020;
   localparam logic [15:0] CE_M   = 16'h0010;
   localparam logic [15:0] SUB_M  = 16'h0008;
   localparam logic [15:0] ALUO_M = 16'h0004;
   localparam logic [15:0] DI_M   = 16'h0002;
   localparam logic [15:0] FL_M   = 16'h0001;

   typedef enum logic [3:0] {
      NOP      = 4'd0,
      LDA      = 4'd1,
      ADD      = 4'd2,
      SUB      = 4'd3,
      STA      = 4'd4,
      LDI      = 4'd5,
      JMP      = 4'd6,
      JC       = 4'd7,
      JZ       = 4'd8,
      OUT      = 4'd9,
      POWEROFF = 4'd10
   } opcode_t;

   // Field order mirrors the bit map, so a plain cast decodes a control word.
   typedef struct packed {
      logic hlt;
      logic ai;
      logic ao;
      logic bi;
      logic mi;
      logic rr;
      logic rw;
      logic ii;
      logic io;
      logic ci;
      logic co;
      logic ce;
      logic sub;
      logic aluo;
      logic di;
      logic fl;
   } ctrl_t;

   function automatic logic multi_driver(input ctrl_t c);
      return (c.ao & (c.rr | c.io | c.co | c.aluo)) |
             (c.rr & (c.io | c.co | c.aluo)) |
             (c.io & (c.co | c.aluo)) |
             (c.co & c.aluo);
   endfunction

endpackage

// File: rtl/datapath_core_if.sv
// Control-word / program-load / status bundle between the sequencer side
// and the datapath.
interface datapath_core_if
   import hm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic [15:0]       ctrl_wrd;
   logic              run;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic [3:0]        command;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              flag_c;
   logic              flag_z;
   logic              halted;
   logic              bus_err;
   logic [ADDR_W-1:0] pc_out;

   modport master (
      output ctrl_wrd, run, prog_we, prog_addr, prog_data,
      input  command, disp_data, disp_valid, flag_c, flag_z, halted, bus_err, pc_out
   );

   modport slave (
      input  ctrl_wrd, run, prog_we, prog_addr, prog_data,
      output command, disp_data, disp_valid, flag_c, flag_z, halted, bus_err, pc_out
   );

endinterface

// File: rtl/datapath_core_alu_unit.sv
// Combinational add/subtract unit; carry is the extra result bit, so for
// subtraction carry=1 means no borrow.
module alu_unit #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] result,
   output logic         c,
   output logic         z
);

   logic [W:0] sum;
   logic [W-1:0] b_eff;

   assign b_eff  = sub ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
   assign result = sum[W-1:0];
   assign c      = sum[W];
   assign z      = (sum[W-1:0] == '0);

endmodule

// File: rtl/datapath_core.sv
// Executes one control word per clock over a single shared bus: registers,
// program/data RAM, ALU and a program-load port used while stopped.
module datapath_core
   import hm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic            CLK,
   input  logic            RST_N,
   datapath_core_if.slave  bus_if
);

   localparam int DEPTH = 1 << ADDR_W;

   ctrl_t             cw;
   logic              exec;
   logic [DATA_W-1:0] bus_val;
   logic [DATA_W-1:0] alu_result;
   logic              alu_c;
   logic              alu_z;

   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [ADDR_W-1:0] mar_reg;
   logic [DATA_W-1:0] ir_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [DATA_W-1:0] disp_reg;
   logic              disp_valid_reg;
   logic              flag_c_reg;
   logic              flag_z_reg;
   logic              halted_reg;
   logic              bus_err_reg;

   logic [DATA_W-1:0] ram [0:DEPTH-1];

   assign cw   = ctrl_t'(bus_if.ctrl_wrd);
   assign exec = bus_if.run && !halted_reg;

   alu_unit #(.W(DATA_W)) u_alu (
      .a      (a_reg),
      .b      (b_reg),
      .sub    (cw.sub),
      .result (alu_result),
      .c      (alu_c),
      .z      (alu_z)
   );

   // Priority bus: AO > RR > IO > CO > ALUO, idle bus reads as zero.
   always_comb begin
      bus_val = '0;
      if (cw.ao)
         bus_val = a_reg;
      else if (cw.rr)
         bus_val = ram[mar_reg];
      else if (cw.io)
         bus_val = {{(DATA_W-4){1'b0}}, ir_reg[3:0]};
      else if (cw.co)
         bus_val = {{(DATA_W-ADDR_W){1'b0}}, pc_reg};
      else if (cw.aluo)
         bus_val = alu_result;
   end

   // RAM shares the reset-guarded block so that no write lands on an edge
   // where reset is held; its contents themselves are never cleared.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_reg          <= '0;
         b_reg          <= '0;
         mar_reg        <= '0;
         ir_reg         <= '0;
         pc_reg         <= '0;
         disp_reg       <= '0;
         disp_valid_reg <= 1'b0;
         flag_c_reg     <= 1'b0;
         flag_z_reg     <= 1'b0;
         halted_reg     <= 1'b0;
         bus_err_reg    <= 1'b0;
      end else begin
         disp_valid_reg <= 1'b0;
         if (exec) begin
            if (cw.ai) a_reg   <= bus_val;
            if (cw.bi) b_reg   <= bus_val;
            if (cw.ii) ir_reg  <= bus_val;
            if (cw.mi) mar_reg <= bus_val[ADDR_W-1:0];
            if (cw.rw) ram[mar_reg] <= bus_val;
            if (cw.ci)
               pc_reg <= bus_val[ADDR_W-1:0];
            else if (cw.ce)
               pc_reg <= pc_reg + ADDR_W'(1);
            if (cw.di) begin
               disp_reg       <= bus_val;
               disp_valid_reg <= 1'b1;
            end
            if (cw.fl) begin
               flag_c_reg <= alu_c;
               flag_z_reg <= alu_z;
            end
            if (cw.hlt) halted_reg <= 1'b1;
            if (multi_driver(cw)) bus_err_reg <= 1'b1;
         end else if (!bus_if.run && bus_if.prog_we) begin
            ram[bus_if.prog_addr] <= bus_if.prog_data;
         end
      end
   end

   assign bus_if.command    = ir_reg[DATA_W-1:DATA_W-4];
   assign bus_if.disp_data  = disp_reg;
   assign bus_if.disp_valid = disp_valid_reg;
   assign bus_if.flag_c     = flag_c_reg;
   assign bus_if.flag_z     = flag_z_reg;
   assign bus_if.halted     = halted_reg;
   assign bus_if.bus_err    = bus_err_reg;
   assign bus_if.pc_out     = pc_reg;

endmodule

// File: tb/tb_datapath_core.sv
// Scenario bench for datapath_core: expected display values are queued when
// a DI word is driven and popped when disp_valid pulses.
module tb_datapath_core;
   import hm_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [7:0] exp_q[$];

   datapath_core_if #(.DATA_W(8), .ADDR_W(4)) dif ();

   datapath_core #(.DATA_W(8), .ADDR_W(4)) dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .bus_if (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Display scoreboard: every disp_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (dif.disp_valid === 1'b1) begin
         logic [7:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL disp_unexpected got=%02h exp=none", dif.disp_data);
         end else begin
            e = exp_q.pop_front();
            if (dif.disp_data !== e) begin
               failures++;
               $display("FAIL disp_data got=%02h exp=%02h", dif.disp_data, e);
            end else begin
               $display("disp ok data=%02h", dif.disp_data);
            end
         end
      end
   end

   task automatic cyc(input logic [15:0] w);
      dif.ctrl_wrd = w;
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [15:0] w, input logic [7:0] e);
      exp_q.push_back(e);
      cyc(w);
   endtask

   task automatic prog(input logic [3:0] addr, input logic [7:0] data);
      dif.prog_we   = 1'b1;
      dif.prog_addr = addr;
      dif.prog_data = data;
      cyc(CE_M);
      dif.prog_we   = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      dif.run = 1'b0;
      dif.prog_we = 1'b0;
      dif.prog_addr = '0;
      dif.prog_data = '0;
      dif.ctrl_wrd = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({dif.command, dif.disp_data, dif.disp_valid, dif.flag_c, dif.flag_z,
           dif.halted, dif.bus_err, dif.pc_out} !== 23'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%06h exp=000000",
                  {dif.command, dif.disp_data, dif.disp_valid, dif.flag_c, dif.flag_z,
                   dif.halted, dif.bus_err, dif.pc_out});
      end
      rst_n = 1'b1;
      cyc('0);
   endtask

   task automatic test_program_load;
      prog(4'd0, 8'h03);
      prog(4'd1, 8'h05);
      prog(4'd2, 8'h07);
      prog(4'd3, 8'h1E);
      prog(4'd5, 8'h2A);
      prog(4'd10, 8'h85);
      prog(4'd14, 8'h2A);
      checks++;
      if (dif.pc_out !== 4'd0) begin
         failures++;
         $display("FAIL ctrl_ignored_when_stopped got=%0d exp=0", dif.pc_out);
      end
      dif.run = 1'b1;
      dif.prog_we = 1'b1;
      dif.prog_addr = 4'd3;
      dif.prog_data = 8'hFF;
      cyc(CO_M | MI_M);
      disp(RR_M | DI_M, 8'h03);
      cyc(RR_M | MI_M);
      cyc(RR_M | II_M);
      checks++;
      if (dif.command !== 4'h1) begin
         failures++;
         $display("FAIL command_after_ii got=%0h exp=1", dif.command);
      end
      disp(RR_M | DI_M, 8'h1E);
      dif.prog_we = 1'b0;
      cyc(IO_M | MI_M);
      cyc(RR_M | AI_M);
      disp(AO_M | DI_M, 8'h2A);
   endtask

   task automatic test_alu;
      cyc(CO_M | MI_M | CE_M);
      cyc(CO_M | MI_M | CE_M);
      cyc(RR_M | AI_M);
      cyc(CO_M | MI_M | CE_M);
      cyc(RR_M | BI_M);
      cyc(ALUO_M | AI_M | FL_M);
      checks++;
      if ({dif.flag_c, dif.flag_z} !== 2'b00) begin
         failures++;
         $display("FAIL add_flags got=%b exp=00", {dif.flag_c, dif.flag_z});
      end
      disp(AO_M | DI_M, 8'h0C);
      cyc(RR_M | AI_M);
      cyc(SUB_M | ALUO_M | BI_M | FL_M);
      checks++;
      if ({dif.flag_c, dif.flag_z} !== 2'b11) begin
         failures++;
         $display("FAIL sub_flags got=%b exp=11", {dif.flag_c, dif.flag_z});
      end
      cyc(AI_M);
      disp(ALUO_M | DI_M, 8'h00);
      checks++;
      if ({dif.flag_c, dif.flag_z} !== 2'b11) begin
         failures++;
         $display("FAIL flags_hold_without_fl got=%b exp=11", {dif.flag_c, dif.flag_z});
      end
      checks++;
      if (dif.pc_out !== 4'd3) begin
         failures++;
         $display("FAIL pc_increment got=%0d exp=3", dif.pc_out);
      end
   endtask

   task automatic test_pc_wrap;
      cyc(IO_M | CI_M);
      cyc(CE_M);
      checks++;
      if (dif.pc_out !== 4'd15) begin
         failures++;
         $display("FAIL pc_load got=%0d exp=15", dif.pc_out);
      end
      cyc(IO_M | MI_M);
      cyc(RR_M | II_M | CE_M);
      checks++;
      if ({dif.pc_out, dif.command} !== {4'd0, 4'h2}) begin
         failures++;
         $display("FAIL pc_wrap_command got=%02h exp=02", {dif.pc_out, dif.command});
      end
      cyc(IO_M | MI_M);
      cyc(RR_M | II_M);
      checks++;
      if (dif.command !== 4'h8) begin
         failures++;
         $display("FAIL command_85 got=%0h exp=8", dif.command);
      end
      cyc(IO_M | MI_M | CI_M | CE_M);
      checks++;
      if (dif.pc_out !== 4'd5) begin
         failures++;
         $display("FAIL pc_ci_wins got=%0d exp=5", dif.pc_out);
      end
      disp(RR_M | DI_M, 8'h2A);
      checks++;
      if (dif.bus_err !== 1'b0) begin
         failures++;
         $display("FAIL bus_err_single_driver got=%b exp=0", dif.bus_err);
      end
   endtask

   task automatic test_display;
      disp(IO_M | DI_M, 8'h05);
      cyc(RR_M | AI_M);
      checks++;
      if (dif.disp_valid !== 1'b0) begin
         failures++;
         $display("FAIL disp_valid_idle got=%b exp=0", dif.disp_valid);
      end
      disp(AO_M | DI_M, 8'h2A);
      checks++;
      if ({dif.disp_valid, dif.disp_data} !== {1'b1, 8'h2A}) begin
         failures++;
         $display("FAIL disp_pulse got=%03h exp=12a", {dif.disp_valid, dif.disp_data});
      end
      cyc('0);
      checks++;
      if ({dif.disp_valid, dif.disp_data} !== {1'b0, 8'h2A}) begin
         failures++;
         $display("FAIL disp_pulse_end got=%03h exp=02a", {dif.disp_valid, dif.disp_data});
      end
   endtask

   task automatic test_bus_err;
      cyc(IO_M | AI_M);
      disp(AO_M | RR_M | DI_M, 8'h05);
      checks++;
      if (dif.bus_err !== 1'b1) begin
         failures++;
         $display("FAIL bus_err_set got=%b exp=1", dif.bus_err);
      end
      cyc('0);
      checks++;
      if (dif.bus_err !== 1'b1) begin
         failures++;
         $display("FAIL bus_err_sticky got=%b exp=1", dif.bus_err);
      end
   endtask

   task automatic test_halt;
      cyc(HLT_M | AI_M);
      checks++;
      if (dif.halted !== 1'b1) begin
         failures++;
         $display("FAIL halted_set got=%b exp=1", dif.halted);
      end
      cyc(BI_M | IO_M | DI_M | CE_M);
      checks++;
      if ({dif.disp_valid, dif.disp_data, dif.pc_out} !== {1'b0, 8'h05, 4'd5}) begin
         failures++;
         $display("FAIL halted_ignores_ctrl got=%04h exp=0055",
                  {dif.disp_valid, dif.disp_data, dif.pc_out});
      end
      dif.run = 1'b0;
      prog(4'd0, 8'h77);
      dif.run = 1'b1;
   endtask

   task automatic test_reset_mid;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({dif.command, dif.disp_data, dif.disp_valid, dif.flag_c, dif.flag_z,
           dif.halted, dif.bus_err, dif.pc_out} !== 23'd0) begin
         failures++;
         $display("FAIL async_reset_outputs got=%06h exp=000000",
                  {dif.command, dif.disp_data, dif.disp_valid, dif.flag_c, dif.flag_z,
                   dif.halted, dif.bus_err, dif.pc_out});
      end
      dif.run = 1'b0;
      dif.prog_we = 1'b1;
      dif.prog_addr = 4'd0;
      dif.prog_data = 8'h00;
      @(posedge clk);
      #1;
      dif.prog_we = 1'b0;
      dif.run = 1'b1;
      rst_n = 1'b1;
      disp(RR_M | DI_M, 8'h77);
      disp(AO_M | DI_M, 8'h00);
      checks++;
      if ({dif.halted, dif.bus_err} !== 2'b00) begin
         failures++;
         $display("FAIL post_reset_status got=%b exp=00", {dif.halted, dif.bus_err});
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_program_load();
      test_alu();
      test_pc_wrap();
      test_display();
      test_bus_err();
      test_halt();
      test_reset_mid();
      cyc('0);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL disp_missing got=%0d pending exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Execution end of the control-word interface. Consumes the 16-bit control word from the microcode sequencer each clock and performs the register transfers it encodes over one shared 8-bit bus.
- Holds the A, B, MAR, IR, PC, flags and display registers, a 16x8 program/data RAM, and the add/sub ALU.
- Returns the current opcode (IR[7:4]) to the sequencer as its `command` input.
- Includes a program-load port, active while the machine is not running.

Parameters:
- DATA_W, 8, bus/register/RAM word width
- ADDR_W, 4, RAM address and PC width (RAM depth = 2**ADDR_W)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- ctrl_wrd  in  16  control word from sequencer, sampled each rising edge
- run  in  1  1 = execute ctrl_wrd; 0 = ignore ctrl_wrd, program port active
- prog_we  in  1  RAM write strobe, honoured only when run=0
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  DATA_W  program-load data
- command  out  4  IR[7:4], to sequencer
- disp_data  out  DATA_W  display register
- disp_valid  out  1  one-cycle pulse when disp_data is loaded
- flag_c  out  1  carry/borrow flag
- flag_z  out  1  zero flag
- halted  out  1  sticky halt indication
- bus_err  out  1  sticky: more than one bus driver was asserted in a single cycle
- pc_out  out  ADDR_W  program counter, for debug

Behaviour:
- Control bit map (bit: function):
  - 15 HLT, 14 AI, 13 AO, 12 BI, 11 MI, 10 RR, 9 RW, 8 II
  - 7 IO, 6 CI, 5 CO, 4 CE, 3 SUB (1 = subtract, 0 = add), 2 ALUO, 1 DI, 0 FL
- Bus (combinational) takes the first asserted driver in priority order AO > RR > IO > CO > ALUO:
  - AO drives A; RR drives ram[MAR]; IO drives {4'b0, IR[3:0]}; CO drives {4'b0, PC}; ALUO drives the ALU result.
  - No driver asserted: bus = 0.
- ALU (combinational):
  - Result = A+B, or A+~B+1 when SUB=1, computed at 9 bits.
  - c = bit 8. For subtraction c=1 means no borrow.
  - z = (result[7:0] == 0).
- Execute condition: run=1 and halted=0. On each rising edge under that condition, every asserted load happens in parallel from the same bus value:
  - AI: A<=bus. BI: B<=bus. II: IR<=bus.
  - MI: MAR<=bus[3:0].
  - RW: ram[MAR]<=bus, using the pre-edge MAR. RW together with MI writes to the old address.
  - CI: PC<=bus[3:0]. CE: PC<=PC+1, wrapping 15 to 0. CI and CE together: CI wins.
  - DI: disp_data<=bus and disp_valid=1 for exactly that following cycle. disp_valid is 0 otherwise.
  - FL: {flag_c, flag_z}<=ALU {c, z}. Flags change only on FL.
  - HLT: halted<=1. Other bits in the same word still take effect on that edge. Every later word is ignored until reset.
  - Two or more of {AO, RR, IO, CO, ALUO} asserted: bus_err<=1 (sticky). Transfers still proceed using the priority bus.
- run=0 or halted=1:
  - ctrl_wrd has no effect and disp_valid=0.
  - run=0 and prog_we=1: ram[prog_addr]<=prog_data. prog_we is ignored while run=1.
- Reset (RST_N=0, async):
  - A, B, MAR, IR, PC, disp_data, flags = 0.
  - disp_valid, halted, bus_err = 0. command = 0.
  - RAM contents are not reset and persist across reset.
  - Reset mid-operation aborts immediately. No RAM write occurs on the edge where reset is asserted.
- Latency: a load asserted in the word present before edge N is visible on outputs after edge N. command follows IR with no extra delay.

Decomposition:
- Shared package `hm_pkg`:
  - control-bit index constants (HLT_B..FL_B) and 16-bit masks, identical to the sequencer encoding
  - opcode constants (LDA=1 .. POWEROFF=10)
  - DATA_W and ADDR_W defaults
- One sub-module `alu_unit`: inputs a, b, sub; outputs result[7:0], c, z. Purely combinational, instantiated once.
- RAM, bus mux and registers stay inline.

Test Plan:
- Reset, then run=0 with prog_we writes ram[3]=0x1E and ram[14]=0x2A; release run=1, then drive:
  - CO|MI -> MAR=0
  - apply IO|MI with IR=0x1E -> MAR=14
  - then RR|AI -> A=0x2A
- A=0x05, B=0x07:
  - ALUO|AI|FL -> A=0x0C, flag_c=0, flag_z=0
  - then with A=0x07: SUB|ALUO|BI|FL -> B=0x00, flag_c=1, flag_z=1
- PC=15:
  - RR|II|CE -> PC=0 (wrap), command=IR[7:4]
  - CO|MI with CI|CE|IO and IR=0x85 -> PC=5 (CI wins)
- AO|DI with A=0x2A -> disp_data=0x2A, disp_valid high exactly 1 cycle. Then ctrl_wrd=0 -> disp_valid=0.
- HLT|AI with AO off, bus=0 -> halted=1, A=0. Subsequent BI|IO words -> B unchanged; run=0 prog writes still succeed.
- AO|RR together -> bus=A, bus_err=1 and stays 1. Assert RST_N=0 mid-run -> all registers 0 immediately, RAM contents unchanged.
